// File: rtl/dwa_element_selector.sv
// rtl/dwa_element_selector.sv - quantizer plus DWA unit-element selector, 2-stage valid/ready pipeline
// Optional qerr_o output enabled by DWA_QERR_EN.
module dwa_element_selector #(
  parameter int WIDTH  = 16,
  parameter int N_ELEM = 8
) (
  input  logic                         clk_i,
  input  logic                         reset_ni,
  input  logic signed [WIDTH-1:0]      sample_i,
  input  logic                         sample_valid_i,
  output logic                         sample_ready_o,
  output logic [N_ELEM-1:0]            elem_en_o,
  output logic [$clog2(N_ELEM):0]      code_o,
  output logic [$clog2(N_ELEM)-1:0]    ptr_o,
  output logic                         elem_valid_o,
  input  logic                         elem_ready_i
`ifdef DWA_QERR_EN
  ,
  output logic signed [WIDTH-1:0]      qerr_o
`endif
);

  localparam int LOG2N  = $clog2(N_ELEM);
  localparam int CODE_W = LOG2N + 1;
  localparam int SHIFT  = WIDTH - LOG2N;
  localparam logic [WIDTH:0]    C_RND  = (WIDTH+1)'(1) << (SHIFT - 1);
  localparam logic [CODE_W-1:0] C_NMAX = CODE_W'(N_ELEM);

  logic                   r_s1_valid;
  logic [CODE_W-1:0]      r_s1_code;
  logic                   r_elem_valid;
  logic [N_ELEM-1:0]      r_elem_en;
  logic [CODE_W-1:0]      r_code;
  logic [LOG2N-1:0]       r_ptr;

  logic [WIDTH:0]         w_u;
  logic [WIDTH:0]         w_ur;
  logic [CODE_W-1:0]      w_code_raw;
  logic [CODE_W-1:0]      w_code;
  logic [N_ELEM-1:0]      w_mask;
  logic [2*N_ELEM-1:0]    w_rot;
  logic [N_ELEM-1:0]      w_en;
  logic [LOG2N-1:0]       w_ptr_next;
  logic                   w_s2_free;
  logic                   w_s1_load;
  logic                   w_s2_load;
  logic                   w_unused;

  // Offset-binary by flipping the sign bit, then round to nearest level.
  assign w_u        = {1'b0, ~sample_i[WIDTH-1], sample_i[WIDTH-2:0]};
  assign w_ur       = w_u + C_RND;
  assign w_code_raw = w_ur[WIDTH:SHIFT];
  assign w_code     = (w_code_raw > C_NMAX) ? C_NMAX : w_code_raw;

  assign w_s2_free      = !r_elem_valid || elem_ready_i;
  assign w_s2_load      = r_s1_valid && w_s2_free;
  assign sample_ready_o = !r_s1_valid || w_s2_free;
  assign w_s1_load      = sample_valid_i && sample_ready_o;

  // Thermometer mask rotated left by the pointer; the upper half of the
  // doubled word is the circular rotation.
  always_comb begin
    w_mask = '0;
    if (r_s1_code[LOG2N])
      w_mask = '1;
    else
      w_mask = (N_ELEM'(1) << r_s1_code[LOG2N-1:0]) - N_ELEM'(1);
  end

  assign w_rot      = {w_mask, w_mask} << r_ptr;
  assign w_en       = w_rot[2*N_ELEM-1:N_ELEM];
  assign w_ptr_next = r_ptr + r_s1_code[LOG2N-1:0];

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_s1_valid   <= 1'b0;
      r_s1_code    <= '0;
      r_elem_valid <= 1'b0;
      r_elem_en    <= '0;
      r_code       <= '0;
      r_ptr        <= '0;
    end else begin
      if (w_s1_load) begin
        r_s1_valid <= 1'b1;
        r_s1_code  <= w_code;
      end else if (w_s2_load) begin
        r_s1_valid <= 1'b0;
      end
      if (w_s2_load) begin
        r_elem_valid <= 1'b1;
        r_elem_en    <= w_en;
        r_code       <= r_s1_code;
        r_ptr        <= w_ptr_next;
      end else if (elem_ready_i) begin
        r_elem_valid <= 1'b0;
      end
    end
  end

  assign elem_en_o    = r_elem_en;
  assign code_o       = r_code;
  assign ptr_o        = r_ptr;
  assign elem_valid_o = r_elem_valid;

`ifdef DWA_QERR_EN
  localparam logic [WIDTH:0] C_HALF = (WIDTH+1)'(1) << (WIDTH - 1);

  logic [WIDTH:0]   w_level;
  logic [WIDTH:0]   w_qerr_full;
  logic [WIDTH-1:0] r_s1_qerr;
  logic [WIDTH-1:0] r_qerr;

  // The error is bounded by half a step, so the top bit is redundant.
  assign w_level     = {w_code, {SHIFT{1'b0}}} - C_HALF;
  assign w_qerr_full = {sample_i[WIDTH-1], sample_i} - w_level;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_s1_qerr <= '0;
      r_qerr    <= '0;
    end else begin
      if (w_s1_load)
        r_s1_qerr <= w_qerr_full[WIDTH-1:0];
      if (w_s2_load)
        r_qerr <= r_s1_qerr;
    end
  end

  assign qerr_o   = r_qerr;
  assign w_unused = ^{w_ur[SHIFT-1:0], w_rot[N_ELEM-1:0], w_qerr_full[WIDTH]};
`else
  assign w_unused = ^{w_ur[SHIFT-1:0], w_rot[N_ELEM-1:0]};
`endif

endmodule
